// File: rtl/controlador_minado.sv
// Mining job controller: accepts a job, loads the parallel hash core, supervises the
// search with a cycle timeout and offers the result downstream over a valid/ready handshake.
module controlador_minado #(
  parameter int unsigned NUM_BLOQUES_PARALELOS = 4,
  parameter int unsigned MAX_CICLOS            = 1024
) (
  input  logic                                clk,
  input  logic                                reset_n,
  // Job intake
  input  logic                                trabajo_valido,
  output logic                                trabajo_listo,
  input  logic [95:0]                         trabajo_datos,
  input  logic [7:0]                          trabajo_target,
  input  logic [31:0]                         trabajo_nonce_base,
  // Hash core side
  output logic [95:0]                         bloque_datos,
  output logic [7:0]                          target,
  output logic [32*NUM_BLOQUES_PARALELOS-1:0] nonce_iniciales,
  output logic                                inicio,
  input  logic [23:0]                         bounty_out,
  input  logic                                terminado_out,
  // Result offer
  output logic                                resultado_valido,
  input  logic                                resultado_listo,
  output logic [23:0]                         resultado_bounty,
  output logic                                resultado_exito,
  output logic [15:0]                         resultado_ciclos
);

  localparam int unsigned NonceW      = 32 * NUM_BLOQUES_PARALELOS;
  localparam logic [15:0] UltimoCiclo = 16'(MAX_CICLOS);

  typedef enum logic [1:0] {
    StReposo,
    StCargar,
    StBuscar,
    StReportar
  } estado_e;

  estado_e             estado_q, estado_d;
  logic [95:0]         bloque_q, bloque_d;
  logic [7:0]          target_q, target_d;
  logic [NonceW-1:0]   nonces_q, nonces_d;
  logic [23:0]         bounty_q, bounty_d;
  logic                exito_q, exito_d;
  logic [15:0]         ciclos_q, ciclos_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= StReposo;
      bloque_q <= '0;
      target_q <= '0;
      nonces_q <= '0;
      bounty_q <= '0;
      exito_q  <= 1'b0;
      ciclos_q <= '0;
    end else begin
      estado_q <= estado_d;
      bloque_q <= bloque_d;
      target_q <= target_d;
      nonces_q <= nonces_d;
      bounty_q <= bounty_d;
      exito_q  <= exito_d;
      ciclos_q <= ciclos_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    bloque_d = bloque_q;
    target_d = target_q;
    nonces_d = nonces_q;
    bounty_d = bounty_q;
    exito_d  = exito_q;
    ciclos_d = ciclos_q;

    unique case (estado_q)
      StReposo: begin
        if (trabajo_valido && trabajo_listo) begin
          bloque_d = trabajo_datos;
          target_d = trabajo_target;
          for (int unsigned i = 0; i < NUM_BLOQUES_PARALELOS; i++) begin
            nonces_d[32*i +: 32] = trabajo_nonce_base + 32'(i);
          end
          estado_d = StCargar;
        end
      end
      StCargar: begin
        ciclos_d = '0;
        estado_d = StBuscar;
      end
      StBuscar: begin
        // ciclos_d counts the current cycle, so the reported value includes it
        ciclos_d = ciclos_q + 16'd1;
        if (terminado_out) begin
          bounty_d = bounty_out;
          exito_d  = 1'b1;
          estado_d = StReportar;
        end else if (ciclos_d == UltimoCiclo) begin
          bounty_d = '0;
          exito_d  = 1'b0;
          estado_d = StReportar;
        end
      end
      StReportar: begin
        if (resultado_listo) begin
          estado_d = StReposo;
        end
      end
      default: estado_d = StReposo;
    endcase
  end

  // Strobes are pure state decodes so reset clears them in the same cycle
  assign trabajo_listo    = (estado_q == StReposo);
  assign inicio           = (estado_q == StCargar);
  assign resultado_valido = (estado_q == StReportar);

  assign bloque_datos     = bloque_q;
  assign target           = target_q;
  assign nonce_iniciales  = nonces_q;
  assign resultado_bounty = bounty_q;
  assign resultado_exito  = exito_q;
  assign resultado_ciclos = ciclos_q;

endmodule

// File: tb/tb_controlador_minado.sv
// Self-checking bench for controlador_minado; expected results go through a scoreboard queue.
module tb_controlador_minado;

  localparam int unsigned NB   = 4;
  localparam int unsigned MAXC = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 trabajo_valido;
  logic                 trabajo_listo;
  logic [95:0]          trabajo_datos;
  logic [7:0]           trabajo_target;
  logic [31:0]          trabajo_nonce_base;
  logic [95:0]          bloque_datos;
  logic [7:0]           target;
  logic [32*NB-1:0]     nonce_iniciales;
  logic                 inicio;
  logic [23:0]          bounty_out;
  logic                 terminado_out;
  logic                 resultado_valido;
  logic                 resultado_listo;
  logic [23:0]          resultado_bounty;
  logic                 resultado_exito;
  logic [15:0]          resultado_ciclos;

  always #5 clk = ~clk;

  controlador_minado #(
    .NUM_BLOQUES_PARALELOS(NB),
    .MAX_CICLOS           (MAXC)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .trabajo_valido    (trabajo_valido),
    .trabajo_listo     (trabajo_listo),
    .trabajo_datos     (trabajo_datos),
    .trabajo_target    (trabajo_target),
    .trabajo_nonce_base(trabajo_nonce_base),
    .bloque_datos      (bloque_datos),
    .target            (target),
    .nonce_iniciales   (nonce_iniciales),
    .inicio            (inicio),
    .bounty_out        (bounty_out),
    .terminado_out     (terminado_out),
    .resultado_valido  (resultado_valido),
    .resultado_listo   (resultado_listo),
    .resultado_bounty  (resultado_bounty),
    .resultado_exito   (resultado_exito),
    .resultado_ciclos  (resultado_ciclos)
  );

  typedef struct {
    logic [23:0] bounty;
    logic        exito;
    logic [15:0] ciclos;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Expected result of a search where terminado_out pulses on BUSCAR cycle 'hit' (0 = never)
  function automatic res_t modelo(input int hit, input logic [23:0] b);
    res_t r;
    if (hit > 0 && hit <= int'(MAXC)) begin
      r.bounty = b;
      r.exito  = 1'b1;
      r.ciclos = 16'(hit);
    end else begin
      r.bounty = 24'h0;
      r.exito  = 1'b0;
      r.ciclos = 16'(MAXC);
    end
    return r;
  endfunction

  task automatic offer_job(input logic [95:0] d, input logic [7:0] t, input logic [31:0] b);
    trabajo_datos      = d;
    trabajo_target     = t;
    trabajo_nonce_base = b;
    trabajo_valido     = 1'b1;
  endtask

  // Leaves the caller at the negedge inside CARGAR, with the offer withdrawn
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (inicio) begin
        ok = 1'b1;
        trabajo_valido = 1'b0;
        return;
      end
    end
    trabajo_valido = 1'b0;
  endtask

  // Drives terminado_out on BUSCAR cycle 'hit'; stops at the first negedge showing a result
  task automatic run_search(input int hit, input logic [23:0] b, output bit got,
                            output int n_inicio);
    int k = 0;
    got      = 1'b0;
    n_inicio = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (inicio) n_inicio++;
      if (resultado_valido) begin
        got           = 1'b1;
        terminado_out = 1'b0;
        bounty_out    = 24'h0;
        return;
      end
      k++;
      terminado_out = (k == hit);
      bounty_out    = (k == hit) ? b : 24'hFFFFFF;
    end
    terminado_out = 1'b0;
  endtask

  task automatic ack();
    resultado_listo = 1'b1;
    @(negedge clk);
    resultado_listo = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({trabajo_listo, inicio, resultado_valido} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_strobes: got %b expected 100", {trabajo_listo, inicio, resultado_valido});
    end
    n_cmp++;
    if ({bloque_datos, target, nonce_iniciales} !== '0) begin
      n_err++;
      $display("FAIL reset_core_regs: got %h expected 0", {bloque_datos, target, nonce_iniciales});
    end
    n_cmp++;
    if ({resultado_bounty, resultado_exito, resultado_ciclos} !== '0) begin
      n_err++;
      $display("FAIL reset_result: got %h expected 0",
               {resultado_bounty, resultado_exito, resultado_ciclos});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nonce_wrap();
    logic [31:0] exp_lane [NB] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    logic [95:0] d = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    bit   ok;
    int   ni;
    res_t e;
    offer_job(d, 8'h0F, 32'hFFFFFFFE);
    sb.push_back(modelo(2, 24'h00_0777));
    wait_accept(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wrap_accept: got none expected inicio"); end
    for (int i = 0; i < int'(NB); i++) begin
      n_cmp++;
      if (nonce_iniciales[32*i +: 32] !== exp_lane[i]) begin
        n_err++;
        $display("FAIL wrap_lane%0d: got %h expected %h", i, nonce_iniciales[32*i +: 32],
                 exp_lane[i]);
      end
    end
    n_cmp++;
    if ({bloque_datos, target} !== {d, 8'h0F}) begin
      n_err++;
      $display("FAIL wrap_capture: got %h expected %h", {bloque_datos, target}, {d, 8'h0F});
    end
    run_search(2, 24'h00_0777, ok, ni);
    n_cmp++;
    if (!ok || ni != 0) begin
      n_err++;
      $display("FAIL wrap_inicio_once: got result=%0d extra_inicio=%0d expected 1/0", ok, ni);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({resultado_bounty, resultado_exito, resultado_ciclos} !== {e.bounty, e.exito, e.ciclos}) begin
      n_err++;
      $display("FAIL wrap_result: got %h/%b/%0d expected %h/%b/%0d", resultado_bounty,
               resultado_exito, resultado_ciclos, e.bounty, e.exito, e.ciclos);
    end
    ack();
    n_cmp++;
    if ({trabajo_listo, resultado_valido, nonce_iniciales[31:0], bloque_datos} !==
        {1'b1, 1'b0, exp_lane[0], d}) begin
      n_err++;
      $display("FAIL wrap_idle_stable: got listo=%b valid=%b lane0=%h", trabajo_listo,
               resultado_valido, nonce_iniciales[31:0]);
    end
  endtask

  // Plain search scenario; 'hit' selects found / timeout / found-on-timeout
  task automatic test_search(input string nombre, input int hit, input logic [23:0] b);
    logic [31:0] base = $urandom;
    logic [95:0] d    = {$urandom, $urandom, $urandom};
    logic [7:0]  t    = 8'($urandom);
    bit   ok;
    int   ni;
    res_t e;
    offer_job(d, t, base);
    sb.push_back(modelo(hit, b));
    wait_accept(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s_accept: got none expected inicio", nombre); end
    n_cmp++;
    if (nonce_iniciales[32*(NB-1) +: 32] !== base + 32'(NB - 1)) begin
      n_err++;
      $display("FAIL %s_lane_last: got %h expected %h", nombre,
               nonce_iniciales[32*(NB-1) +: 32], base + 32'(NB - 1));
    end
    // A completion seen during CARGAR must be ignored
    terminado_out = 1'b1;
    bounty_out    = 24'h123456;
    run_search(hit, b, ok, ni);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s_timeout: got no result expected one", nombre); end
    e = sb.pop_front();
    n_cmp++;
    if ({resultado_bounty, resultado_exito, resultado_ciclos} !== {e.bounty, e.exito, e.ciclos}) begin
      n_err++;
      $display("FAIL %s_result: got %h/%b/%0d expected %h/%b/%0d", nombre, resultado_bounty,
               resultado_exito, resultado_ciclos, e.bounty, e.exito, e.ciclos);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [95:0] d2 = 96'hCAFE_0000_1111_2222_3333_4444;
    bit   ok;
    int   ni;
    res_t e;
    offer_job(96'h1, 8'h01, 32'h10);
    sb.push_back(modelo(3, 24'h0000C3));
    wait_accept(ok);
    run_search(3, 24'h0000C3, ok, ni);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL bp_first: got no result expected one"); end
    e = sb.pop_front();
    offer_job(d2, 8'h22, 32'h200);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({resultado_valido, trabajo_listo, inicio, resultado_bounty, resultado_exito,
           resultado_ciclos, bloque_datos} !==
          {3'b100, e.bounty, e.exito, e.ciclos, 96'h1}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b l=%b i=%b %h/%b/%0d expected 100 %h/%b/%0d", c,
                 resultado_valido, trabajo_listo, inicio, resultado_bounty, resultado_exito,
                 resultado_ciclos, e.bounty, e.exito, e.ciclos);
      end
    end
    ack();
    n_cmp++;
    if ({trabajo_listo, resultado_valido} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_release: got %b expected 10", {trabajo_listo, resultado_valido});
    end
    sb.push_back(modelo(4, 24'h00BEEF));
    @(negedge clk);
    trabajo_valido = 1'b0;
    n_cmp++;
    if ({inicio, bloque_datos, target} !== {1'b1, d2, 8'h22}) begin
      n_err++;
      $display("FAIL bp_held_job: got i=%b %h expected 1 %h", inicio, bloque_datos, d2);
    end
    run_search(4, 24'h00BEEF, ok, ni);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {resultado_bounty, resultado_exito, resultado_ciclos} !==
               {e.bounty, e.exito, e.ciclos}) begin
      n_err++;
      $display("FAIL bp_second: got %h/%b/%0d expected %h/%b/%0d", resultado_bounty,
               resultado_exito, resultado_ciclos, e.bounty, e.exito, e.ciclos);
    end
    ack();
  endtask

  task automatic test_reset_mid_search();
    bit ok;
    offer_job(96'h5A5A, 8'h33, 32'h77);
    wait_accept(ok);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({inicio, resultado_valido, trabajo_listo, resultado_ciclos, bloque_datos} !==
        {3'b001, 16'h0, 96'h0}) begin
      n_err++;
      $display("FAIL rst_mid: got i=%b v=%b l=%b ciclos=%0d expected 0/0/1/0", inicio,
               resultado_valido, trabajo_listo, resultado_ciclos);
    end
    @(negedge clk);
    reset_n       = 1'b1;
    terminado_out = 1'b1;
    bounty_out    = 24'hABCDEF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({resultado_valido, trabajo_listo, inicio} !== 3'b010) begin
        n_err++;
        $display("FAIL rst_idle%0d: got %b expected 010", c,
                 {resultado_valido, trabajo_listo, inicio});
      end
    end
    terminado_out = 1'b0;
    bounty_out    = 24'h0;
  endtask

  initial begin
    reset_n            = 1'b0;
    trabajo_valido     = 1'b0;
    trabajo_datos      = '0;
    trabajo_target     = '0;
    trabajo_nonce_base = '0;
    bounty_out         = '0;
    terminado_out      = 1'b0;
    resultado_listo    = 1'b0;
    test_reset();
    test_nonce_wrap();
    test_search("found", 5, 24'h00A1B2);
    test_search("timeout", 0, 24'h0);
    test_search("timeout_hit", int'(MAXC), 24'h00F00D);
    test_search("first_cycle", 1, 24'h000042);
    test_back_to_back();
    test_reset_mid_search();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/controlador_minado.md
CONTROLADOR_MINADO -- requirements
Module: controlador_minado

Interface
REQ-001 The block SHALL have parameter NUM_BLOQUES_PARALELOS, default 4, giving the number of parallel hash lanes in the downstream micro_ucr_hash_mod.
REQ-002 The block SHALL have parameter MAX_CICLOS, default 1024, giving the search timeout in clock cycles; legal range is 1..65535.
REQ-003 The block SHALL use one clock, clk; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 trabajo_valido  input  1  upstream job offer.
REQ-007 trabajo_listo  output  1  block accepts a job.
REQ-008 trabajo_datos  input  96  block header data.
REQ-009 trabajo_target  input  8  difficulty target.
REQ-010 trabajo_nonce_base  input  32  first nonce of the job.
REQ-011 bloque_datos  output  96  registered header to the hash core.
REQ-012 target  output  8  registered target to the hash core.
REQ-013 nonce_iniciales  output  32*NUM_BLOQUES_PARALELOS  per-lane starting nonces.
REQ-014 inicio  output  1  hash-core load strobe.
REQ-015 bounty_out  input  24  winning hash from the core.
REQ-016 terminado_out  input  1  core found a hash meeting the target.
REQ-017 resultado_valido  output  1  result offer downstream.
REQ-018 resultado_listo  input  1  downstream accepts the result.
REQ-019 resultado_bounty  output  24  captured bounty; 0 on timeout.
REQ-020 resultado_exito  output  1  1 = found, 0 = timeout.
REQ-021 resultado_ciclos  output  16  search cycles consumed.

Function
REQ-022 The state machine SHALL have four states: REPOSO, CARGAR, BUSCAR and REPORTAR.
REQ-023 trabajo_listo SHALL be 1 only in REPOSO.
REQ-024 In REPOSO, a job SHALL be accepted when trabajo_valido and trabajo_listo are both 1 on a rising edge.
- On acceptance, trabajo_datos and trabajo_target SHALL be captured into bloque_datos and target.
- The block SHALL then go to CARGAR.
REQ-025 On acceptance, lane i of nonce_iniciales[32*i +: 32] SHALL be loaded with (trabajo_nonce_base + i) mod 2^32.
REQ-026 The block SHALL spend exactly one cycle in CARGAR.
- inicio SHALL be 1 in that cycle and 0 in every other state.
- The cycle counter SHALL clear to 0.
- The block SHALL then go to BUSCAR.
REQ-027 In BUSCAR, the counter SHALL increment by 1 each cycle.
- resultado_ciclos SHALL equal the number of BUSCAR cycles elapsed, including the terminating cycle.
REQ-028 In BUSCAR, if terminado_out = 1, the block SHALL capture bounty_out into resultado_bounty, set resultado_exito = 1, and go to REPORTAR.
REQ-029 In BUSCAR, if terminado_out = 0 on the MAX_CICLOS-th cycle, the block SHALL set resultado_bounty = 0 and resultado_exito = 0, and go to REPORTAR.
REQ-030 If terminado_out = 1 on the timeout cycle, the result SHALL be reported as found (exito = 1).
REQ-031 terminado_out and bounty_out SHALL be ignored outside BUSCAR.
REQ-032 In REPORTAR, resultado_valido SHALL be 1.
- All resultado_* outputs SHALL hold stable until resultado_listo = 1 on a rising edge.
- After that handshake the block SHALL return to REPOSO.
REQ-033 bloque_datos, target and nonce_iniciales SHALL remain stable from CARGAR until the next job is accepted.
REQ-034 A job offered in any state other than REPOSO SHALL NOT be accepted; the upstream holds it.
REQ-035 The counter SHALL NOT wrap, because MAX_CICLOS ≤ 65535.

Reset
REQ-036 While reset_n = 0, the block SHALL be in REPOSO.
REQ-037 While reset_n = 0, all registered outputs SHALL be 0 (bloque_datos, target, nonce_iniciales, inicio, resultado_valido, resultado_bounty, resultado_exito, resultado_ciclos), and trabajo_listo SHALL be 1.
REQ-038 Reset asserted in any state, including mid-BUSCAR or REPORTAR, SHALL abort the job with no result emitted.

Verification
REQ-039 Reset: assert reset_n = 0 mid-BUSCAR -> same cycle inicio = 0, resultado_valido = 0, trabajo_listo = 1; after release the block is idle.
REQ-040 Nonce wrap (N = 4): trabajo_nonce_base = 0xFFFFFFFE -> lanes 0..3 = 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001; inicio is high for exactly one cycle.
REQ-041 Found: terminado_out = 1 with bounty_out = 0x00A1B2 on the 5th BUSCAR cycle -> resultado_valido = 1, bounty = 0x00A1B2, exito = 1, ciclos = 5.
REQ-042 Timeout (MAX_CICLOS = 16): terminado_out held 0 -> bounty = 0, exito = 0, ciclos = 16; with terminado_out = 1 on cycle 16 -> exito = 1, ciclos = 16.
REQ-043 Backpressure: resultado_listo = 0 for 10 cycles while trabajo_valido = 1 -> resultado_* stable, trabajo_listo = 0, no new job accepted; resultado_listo = 1 -> REPOSO, and the held job is accepted on the next edge.
